// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle for branch_predictor.
// master drives f_*/r_*, slave returns p_*, redirect and counts.
interface branch_predictor_if;
  logic        f_valid;
  logic        f_stall;
  logic [31:0] f_pc;
  logic        p_valid;
  logic        p_taken;
  logic [31:0] p_target;
  logic        r_valid;
  logic        r_is_br;
  logic [31:0] r_pc;
  logic        r_bcomp;
  logic [31:0] r_target;
  logic        r_pred_taken;
  logic [31:0] r_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  modport master (
    output f_valid, f_stall, f_pc,
    output r_valid, r_is_br, r_pc, r_bcomp,
    output r_target, r_pred_taken, r_pred_target,
    input  p_valid, p_taken, p_target,
    input  mispredict, redirect_pc,
    input  br_count, mp_count
  );

  modport slave (
    input  f_valid, f_stall, f_pc,
    input  r_valid, r_is_br, r_pc, r_bcomp,
    input  r_target, r_pred_taken, r_pred_target,
    output p_valid, p_taken, p_target,
    output mispredict, redirect_pc,
    output br_count, mp_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal 2-bit counter table + BTB, trained by execute outcome.
// Ports: clk, rst (sync, active-high), bp (slave: lookup/resolve/perf).
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int CNT_INIT   = 1
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int ENT  = 1 << INDEX_BITS;
  localparam int TAGW = 32 - INDEX_BITS - 2;

  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [TAGW-1:0]       tag_t;

  logic [1:0]     cnt_q [ENT];
  logic [ENT-1:0] btb_v_q;
  tag_t           btb_tag_q [ENT];
  logic [31:0]    btb_tgt_q [ENT];

  logic        p_valid_q;
  logic        p_taken_q;
  logic [31:0] p_target_q;
  logic        mp_q;
  logic [31:0] redir_q;
  logic [31:0] br_q;
  logic [31:0] mpc_q;

  idx_t        fidx;
  tag_t        ftag;
  idx_t        ridx;
  tag_t        rtag;
  logic        hit;
  logic        p_taken_d;
  logic [31:0] p_target_d;
  logic        train;
  logic        mp_d;
  logic [31:0] redir_d;
  logic [1:0]  cnt_d;

  assign fidx = bp.f_pc[INDEX_BITS+1:2];
  assign ftag = bp.f_pc[31:INDEX_BITS+2];
  assign ridx = bp.r_pc[INDEX_BITS+1:2];
  assign rtag = bp.r_pc[31:INDEX_BITS+2];

  always_comb begin
    hit        = btb_v_q[fidx] && (btb_tag_q[fidx] == ftag);
    p_taken_d  = hit && cnt_q[fidx][1];
    p_target_d = p_taken_d ? btb_tgt_q[fidx] : bp.f_pc + 32'd4;
    train      = bp.r_valid && bp.r_is_br;
    // A taken branch to a stale target is as wrong as a bad direction.
    mp_d       = train && ((bp.r_bcomp != bp.r_pred_taken) ||
                 (bp.r_bcomp && (bp.r_pred_target != bp.r_target)));
    redir_d    = bp.r_bcomp ? bp.r_target : bp.r_pc + 32'd4;
    cnt_d      = cnt_q[ridx];
    unique case (1'b1)
      bp.r_bcomp && (cnt_q[ridx] != 2'b11):
        cnt_d = cnt_q[ridx] + 2'd1;
      !bp.r_bcomp && (cnt_q[ridx] != 2'b00):
        cnt_d = cnt_q[ridx] - 2'd1;
      default:
        cnt_d = cnt_q[ridx];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENT; i++) begin
        cnt_q[i] <= 2'(CNT_INIT);
      end
      btb_v_q    <= '0;
      p_valid_q  <= 1'b0;
      p_taken_q  <= 1'b0;
      p_target_q <= '0;
      mp_q       <= 1'b0;
      redir_q    <= '0;
      br_q       <= '0;
      mpc_q      <= '0;
    end else begin
      if (!bp.f_stall) begin
        p_valid_q <= bp.f_valid;
        if (bp.f_valid) begin
          p_taken_q  <= p_taken_d;
          p_target_q <= p_target_d;
        end
      end
      mp_q <= mp_d;
      if (mp_d) begin
        redir_q <= redir_d;
        if (mpc_q != '1) mpc_q <= mpc_q + 32'd1;
      end
      if (train) begin
        cnt_q[ridx] <= cnt_d;
        if (bp.r_bcomp) btb_v_q[ridx] <= 1'b1;
        if (br_q != '1) br_q <= br_q + 32'd1;
      end
    end
  end

  // Tag/target need no reset: gated by btb_v_q.
  always_ff @(posedge clk) begin
    if (!rst && train && bp.r_bcomp) begin
      btb_tag_q[ridx] <= rtag;
      btb_tgt_q[ridx] <= bp.r_target;
    end
  end

  assign bp.p_valid     = p_valid_q;
  assign bp.p_taken     = p_taken_q;
  assign bp.p_target    = p_target_q;
  assign bp.mispredict  = mp_q;
  assign bp.redirect_pc = redir_q;
  assign bp.br_count    = br_q;
  assign bp.mp_count    = mpc_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor.
// Model predicts p_* and resolve outputs per cycle.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if bp();
  branch_predictor dut (.clk(clk), .rst(rst), .bp(bp));

  typedef struct packed {
    logic fv; logic fs; logic [31:0] fpc;
    logic rv; logic rb; logic [31:0] rpc;
    logic bc; logic [31:0] rt;
    logic pt; logic [31:0] ptg;
  } stim_t;
  typedef struct packed {
    logic v; logic t; logic [31:0] tg;
  } pexp_t;
  typedef struct packed {
    logic mp; logic [31:0] rd;
    logic [31:0] br; logic [31:0] mc;
  } rexp_t;

  pexp_t pq[$];
  rexp_t rq[$];
  pexp_t m_p;
  rexp_t m_r;
  logic [1:0]  m_cnt [64];
  logic        m_v   [64];
  logic [23:0] m_tag [64];
  logic [31:0] m_tgt [64];
  int n_chk = 0;
  int n_fail = 0;

  function automatic stim_t lk(input logic [31:0] pc);
    stim_t s = '0;
    s.fv = 1'b1; s.fpc = pc;
    return s;
  endfunction

  function automatic stim_t stl(input logic [31:0] pc);
    stim_t s = '0;
    s.fv = 1'b1; s.fs = 1'b1; s.fpc = pc;
    return s;
  endfunction

  function automatic stim_t rs(input logic [31:0] pc,
    input logic bc, input logic [31:0] rt,
    input logic pt, input logic [31:0] ptg);
    stim_t s = '0;
    s.rv = 1'b1; s.rb = 1'b1; s.rpc = pc;
    s.bc = bc; s.rt = rt; s.pt = pt; s.ptg = ptg;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bp.f_valid = s.fv;  bp.f_stall = s.fs;
    bp.f_pc = s.fpc;    bp.r_valid = s.rv;
    bp.r_is_br = s.rb;  bp.r_pc = s.rpc;
    bp.r_bcomp = s.bc;  bp.r_target = s.rt;
    bp.r_pred_taken = s.pt;
    bp.r_pred_target = s.ptg;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_cnt[i] = 2'd1; m_v[i] = 1'b0;
      m_tag[i] = '0;   m_tgt[i] = '0;
    end
    m_p = '0; m_r = '0;
    pq.delete(); rq.delete();
  endtask

  task automatic apply_reset(input stim_t s);
    drive(s);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Model one edge: lookup sees pre-training state.
  task automatic step(input stim_t s);
    int fi, ri;
    logic mp;
    fi = int'(s.fpc[7:2]);
    ri = int'(s.rpc[7:2]);
    if (!s.fs) begin
      if (s.fv) begin
        m_p.v = 1'b1;
        m_p.t = m_v[fi] && (m_tag[fi] == s.fpc[31:8])
                && m_cnt[fi][1];
        m_p.tg = m_p.t ? m_tgt[fi] : s.fpc + 32'd4;
      end else begin
        m_p.v = 1'b0;
      end
    end
    mp = s.rv && s.rb && ((s.bc != s.pt) ||
         (s.bc && (s.ptg != s.rt)));
    m_r.mp = mp;
    if (mp) m_r.rd = s.bc ? s.rt : s.rpc + 32'd4;
    if (s.rv && s.rb) begin
      if (m_r.br != 32'hFFFF_FFFF) m_r.br = m_r.br + 32'd1;
      if (s.bc) begin
        if (m_cnt[ri] < 2'd3) m_cnt[ri] = m_cnt[ri] + 2'd1;
        m_v[ri] = 1'b1;
        m_tag[ri] = s.rpc[31:8];
        m_tgt[ri] = s.rt;
      end else if (m_cnt[ri] > 2'd0) begin
        m_cnt[ri] = m_cnt[ri] - 2'd1;
      end
    end
    if (mp && m_r.mc != 32'hFFFF_FFFF) m_r.mc = m_r.mc + 32'd1;
    pq.push_back(m_p);
    rq.push_back(m_r);
    drive(s);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset('0);
    apply_reset('0);
    n_chk++;
    if ({bp.p_valid, bp.p_taken} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_p: got v=%b t=%b, exp 0 0",
               bp.p_valid, bp.p_taken);
    end
    n_chk++;
    if (bp.p_target !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ptgt: got %h, exp 0", bp.p_target);
    end
    n_chk++;
    if ({bp.mispredict, bp.redirect_pc} !== 33'h0) begin
      n_fail++;
      $display("FAIL reset_mp: got mp=%b rd=%h, exp 0",
               bp.mispredict, bp.redirect_pc);
    end
    n_chk++;
    if ({bp.br_count, bp.mp_count} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_cnt: got br=%0d mp=%0d, exp 0",
               bp.br_count, bp.mp_count);
    end
  endtask

  task automatic test_lookup();
    stim_t sq[$];
    pexp_t pe;
    rexp_t re;
    sq = '{lk(32'h100), lk(32'hFFFF_FFFC), stim_t'('0), lk(32'h40)};
    foreach (sq[k]) begin
      step(sq[k]);
      pe = pq.pop_front();
      re = rq.pop_front();
      n_chk++;
      if ({bp.p_valid, bp.p_taken, bp.p_target} !== pe) begin
        n_fail++;
        $display("FAIL lookup[%0d]: got v=%b t=%b tg=%h, exp v=%b t=%b tg=%h",
                 k, bp.p_valid, bp.p_taken, bp.p_target, pe.v, pe.t, pe.tg);
      end
      n_chk++;
      if ({bp.mispredict, bp.redirect_pc, bp.br_count,
           bp.mp_count} !== re) begin
        n_fail++;
        $display("FAIL lookup_r[%0d]: got mp=%b rd=%h br=%0d mc=%0d, exp mp=%b rd=%h br=%0d mc=%0d",
                 k, bp.mispredict, bp.redirect_pc, bp.br_count, bp.mp_count,
                 re.mp, re.rd, re.br, re.mc);
      end
    end
  endtask

  task automatic test_mispredict();
    stim_t sq[$];
    stim_t nb;
    pexp_t pe;
    rexp_t re;
    apply_reset('0);
    nb = rs(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    nb.rb = 1'b0;
    sq = '{lk(32'h100),
           rs(32'h100, 1'b1, 32'h80, 1'b0, 32'h104),
           stim_t'('0), nb,
           rs(32'h100, 1'b1, 32'h80, 1'b1, 32'h80),
           rs(32'h100, 1'b1, 32'h80, 1'b1, 32'h80),
           lk(32'h100)};
    foreach (sq[k]) begin
      step(sq[k]);
      pe = pq.pop_front();
      re = rq.pop_front();
      n_chk++;
      if ({bp.p_valid, bp.p_taken, bp.p_target} !== pe) begin
        n_fail++;
        $display("FAIL mispred_p[%0d]: got v=%b t=%b tg=%h, exp v=%b t=%b tg=%h",
                 k, bp.p_valid, bp.p_taken, bp.p_target, pe.v, pe.t, pe.tg);
      end
      n_chk++;
      if ({bp.mispredict, bp.redirect_pc, bp.br_count,
           bp.mp_count} !== re) begin
        n_fail++;
        $display("FAIL mispred_r[%0d]: got mp=%b rd=%h br=%0d mc=%0d, exp mp=%b rd=%h br=%0d mc=%0d",
                 k, bp.mispredict, bp.redirect_pc, bp.br_count, bp.mp_count,
                 re.mp, re.rd, re.br, re.mc);
      end
    end
    n_chk++;
    if ({bp.p_taken, bp.p_target} !== {1'b1, 32'h80}) begin
      n_fail++;
      $display("FAIL trained_taken: got t=%b tg=%h, exp 1 00000080",
               bp.p_taken, bp.p_target);
    end
    n_chk++;
    if ({bp.redirect_pc, bp.br_count, bp.mp_count} !==
        {32'h80, 32'd3, 32'd1}) begin
      n_fail++;
      $display("FAIL mp_counts: got rd=%h br=%0d mc=%0d, exp 80 3 1",
               bp.redirect_pc, bp.br_count, bp.mp_count);
    end
  endtask

  task automatic test_saturation();
    stim_t sq[$];
    stim_t tk, nt;
    pexp_t pe;
    rexp_t re;
    apply_reset('0);
    tk = rs(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    nt = rs(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    sq = '{rs(32'h100, 1'b1, 32'h80, 1'b0, 32'h104),
           tk, tk, tk, tk,
           rs(32'h100, 1'b0, 32'h80, 1'b1, 32'h80),
           lk(32'h100), nt, nt, nt, lk(32'h100)};
    foreach (sq[k]) begin
      step(sq[k]);
      pe = pq.pop_front();
      re = rq.pop_front();
      n_chk++;
      if ({bp.p_valid, bp.p_taken, bp.p_target} !== pe) begin
        n_fail++;
        $display("FAIL sat_p[%0d]: got v=%b t=%b tg=%h, exp v=%b t=%b tg=%h",
                 k, bp.p_valid, bp.p_taken, bp.p_target, pe.v, pe.t, pe.tg);
      end
      n_chk++;
      if ({bp.mispredict, bp.redirect_pc, bp.br_count,
           bp.mp_count} !== re) begin
        n_fail++;
        $display("FAIL sat_r[%0d]: got mp=%b rd=%h br=%0d mc=%0d, exp mp=%b rd=%h br=%0d mc=%0d",
                 k, bp.mispredict, bp.redirect_pc, bp.br_count, bp.mp_count,
                 re.mp, re.rd, re.br, re.mc);
      end
    end
    n_chk++;
    if ({bp.p_taken, bp.p_target, bp.br_count} !==
        {1'b0, 32'h104, 32'd9}) begin
      n_fail++;
      $display("FAIL sat_final: got t=%b tg=%h br=%0d, exp 0 104 9",
               bp.p_taken, bp.p_target, bp.br_count);
    end
  endtask

  task automatic test_alias();
    stim_t sq[$];
    stim_t tk;
    pexp_t pe;
    rexp_t re;
    tk = rs(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    sq = '{tk, tk, tk, lk(32'h200), lk(32'h100),
           rs(32'h200, 1'b0, 32'h0, 1'b0, 32'h0),
           lk(32'h100), lk(32'h200)};
    foreach (sq[k]) begin
      step(sq[k]);
      pe = pq.pop_front();
      re = rq.pop_front();
      n_chk++;
      if ({bp.p_valid, bp.p_taken, bp.p_target} !== pe) begin
        n_fail++;
        $display("FAIL alias_p[%0d]: got v=%b t=%b tg=%h, exp v=%b t=%b tg=%h",
                 k, bp.p_valid, bp.p_taken, bp.p_target, pe.v, pe.t, pe.tg);
      end
      n_chk++;
      if ({bp.mispredict, bp.redirect_pc, bp.br_count,
           bp.mp_count} !== re) begin
        n_fail++;
        $display("FAIL alias_r[%0d]: got mp=%b rd=%h br=%0d mc=%0d, exp mp=%b rd=%h br=%0d mc=%0d",
                 k, bp.mispredict, bp.redirect_pc, bp.br_count, bp.mp_count,
                 re.mp, re.rd, re.br, re.mc);
      end
    end
    n_chk++;
    if ({bp.p_taken, bp.p_target} !== {1'b0, 32'h204}) begin
      n_fail++;
      $display("FAIL alias_tag: got t=%b tg=%h, exp 0 00000204",
               bp.p_taken, bp.p_target);
    end
  endtask

  task automatic test_back_to_back();
    stim_t sq[$];
    stim_t tk, nt;
    pexp_t pe;
    rexp_t re;
    apply_reset('0);
    tk = rs(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    nt = rs(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    sq = '{lk(32'h100) | rs(32'h100, 1'b1, 32'h80, 1'b0, 32'h104),
           tk, lk(32'h100), nt, lk(32'h100) | nt, lk(32'h100)};
    foreach (sq[k]) begin
      step(sq[k]);
      pe = pq.pop_front();
      re = rq.pop_front();
      n_chk++;
      if ({bp.p_valid, bp.p_taken, bp.p_target} !== pe) begin
        n_fail++;
        $display("FAIL b2b_p[%0d]: got v=%b t=%b tg=%h, exp v=%b t=%b tg=%h",
                 k, bp.p_valid, bp.p_taken, bp.p_target, pe.v, pe.t, pe.tg);
      end
      n_chk++;
      if ({bp.mispredict, bp.redirect_pc, bp.br_count,
           bp.mp_count} !== re) begin
        n_fail++;
        $display("FAIL b2b_r[%0d]: got mp=%b rd=%h br=%0d mc=%0d, exp mp=%b rd=%h br=%0d mc=%0d",
                 k, bp.mispredict, bp.redirect_pc, bp.br_count, bp.mp_count,
                 re.mp, re.rd, re.br, re.mc);
      end
    end
    n_chk++;
    if ({bp.p_taken, bp.p_target} !== {1'b0, 32'h104}) begin
      n_fail++;
      $display("FAIL b2b_final: got t=%b tg=%h, exp 0 00000104",
               bp.p_taken, bp.p_target);
    end
  endtask

  task automatic test_stall_reset();
    stim_t sq[$];
    stim_t tk, st;
    pexp_t pe;
    rexp_t re;
    tk = rs(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    st = stl(32'h300) | rs(32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
    sq = '{tk, tk, tk, lk(32'h100), st, st, st, lk(32'h100),
           rs(32'h100, 1'b1, 32'h40, 1'b0, 32'h0)};
    foreach (sq[k]) begin
      step(sq[k]);
      pe = pq.pop_front();
      re = rq.pop_front();
      n_chk++;
      if ({bp.p_valid, bp.p_taken, bp.p_target} !== pe) begin
        n_fail++;
        $display("FAIL stall_p[%0d]: got v=%b t=%b tg=%h, exp v=%b t=%b tg=%h",
                 k, bp.p_valid, bp.p_taken, bp.p_target, pe.v, pe.t, pe.tg);
      end
      n_chk++;
      if ({bp.mispredict, bp.redirect_pc, bp.br_count,
           bp.mp_count} !== re) begin
        n_fail++;
        $display("FAIL stall_r[%0d]: got mp=%b rd=%h br=%0d mc=%0d, exp mp=%b rd=%h br=%0d mc=%0d",
                 k, bp.mispredict, bp.redirect_pc, bp.br_count, bp.mp_count,
                 re.mp, re.rd, re.br, re.mc);
      end
    end
    apply_reset(lk(32'h100) | rs(32'h100, 1'b1, 32'h40, 1'b0, 32'h0));
    n_chk++;
    if ({bp.mispredict, bp.p_valid, bp.br_count, bp.mp_count} !== 66'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got mp=%b v=%b br=%0d mc=%0d, exp all 0",
               bp.mispredict, bp.p_valid, bp.br_count, bp.mp_count);
    end
    step(lk(32'h100));
    pe = pq.pop_front();
    re = rq.pop_front();
    n_chk++;
    if ({bp.p_valid, bp.p_taken, bp.p_target} !== {1'b1, 1'b0, 32'h104}) begin
      n_fail++;
      $display("FAIL rst_lookup: got v=%b t=%b tg=%h, exp 1 0 00000104",
               bp.p_valid, bp.p_taken, bp.p_target);
    end
    n_chk++;
    if ({bp.mispredict, bp.br_count} !== re[96:64] || bp.br_count !== re.br) begin
      n_fail++;
      $display("FAIL rst_notrain: got mp=%b br=%0d, exp mp=%b br=%0d",
               bp.mispredict, bp.br_count, re.mp, re.br);
    end
  endtask

  initial begin
    drive('0);
    rst = 1'b1;
    test_reset();
    test_lookup();
    test_mispredict();
    test_saturation();
    test_alias();
    test_back_to_back();
    test_stall_reset();
    drive('0);
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
